// File: rtl/quiz_scorekeeper_pkg.sv
// quiz_scorekeeper_pkg: shared state encoding, sizes and defaults for the
// quiz scorekeeper and its buzzer arbiter.
package quiz_scorekeeper_pkg;

  localparam int PLAYER_N          = 4;
  localparam int MARK_W            = 4;
  localparam int DEF_MAX_MARK      = 10;
  localparam int DEF_ANSWER_CYCLES = 500000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    LOCKED    = 2'd2,
    GAME_OVER = 2'd3
  } qs_state_t;

  typedef logic [PLAYER_N-1:0] player_vec_t;

  // Increment a mark, pinning it at the winning score.
  function automatic logic [MARK_W-1:0] mark_inc_sat(input logic [MARK_W-1:0] m,
                                                     input logic [MARK_W-1:0] max_m);
    return (m >= max_m) ? max_m : MARK_W'(m + 1'b1);
  endfunction

endpackage

// File: rtl/quiz_scorekeeper_arbiter.sv
// buzz_priority_arbiter: combinational lowest-index one-hot picker.
// A lane is granted when it requests and no lower lane requests, so ties
// always favour player one.
module buzz_priority_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // blocked[i] is high when any lane below i is requesting
  logic [N:0] blocked;

  assign blocked[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign grant[i]     = req[i] & ~blocked[i];
    assign blocked[i+1] = blocked[i] | req[i];
  end

endmodule

// File: rtl/quiz_scorekeeper.sv
// quiz_scorekeeper: buzzer arbitration, question/answer FSM and per-player
// marks feeding the seven-segment display stage.
// Optional build macro FALSE_START_PENALTY_EN: buzzing while IDLE locks that
// player out of the next question.
module quiz_scorekeeper
  import quiz_scorekeeper_pkg::*;
#(
  parameter int MAX_MARK      = DEF_MAX_MARK,
  parameter int ANSWER_CYCLES = DEF_ANSWER_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buzz,
  input  logic       start,
  input  logic       judge_ok,
  input  logic       judge_ng,
  input  logic       new_game,
  output logic [3:0] answer,
  output logic [3:0] mark_one,
  output logic [3:0] mark_two,
  output logic [3:0] mark_three,
  output logic [3:0] mark_four,
  output logic       armed,
  output logic [3:0] winner
);

  localparam logic [MARK_W-1:0] MAX_M   = MARK_W'(MAX_MARK);
  localparam logic [CNT_W-1:0]  T_LAST  = CNT_W'(ANSWER_CYCLES - 1);

  qs_state_t                            state, state_n;
  logic [PLAYER_N-1:0][MARK_W-1:0]      marks, marks_n;
  player_vec_t                          excluded, excluded_n;
  player_vec_t                          answer_n, winner_n;
  player_vec_t                          eligible, grant;
  logic [CNT_W-1:0]                     timer, timer_n;
  logic                                 start_q, ok_q, ng_q;
  logic                                 start_e, ok_e, ng_e;
  logic                                 timeout, win_hit;
`ifdef FALSE_START_PENALTY_EN
  player_vec_t                          fs_flags, fs_flags_n, fs_load;
`endif

  // Input edge history for the host strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      ok_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      start_q <= start;
      ok_q    <= judge_ok;
      ng_q    <= judge_ng;
    end
  end

  assign start_e = start    & ~start_q;
  assign ok_e    = judge_ok & ~ok_q;
  assign ng_e    = judge_ng & ~ng_q;
  assign timeout = (timer == T_LAST);

  assign eligible = buzz & ~excluded;

  buzz_priority_arbiter #(.N(PLAYER_N)) u_arb (
    .req   (eligible),
    .grant (grant)
  );

  // State and datapath registers; reset aborts any open answer untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      answer   <= '0;
      winner   <= '0;
      excluded <= '0;
      marks    <= '0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      answer   <= answer_n;
      winner   <= winner_n;
      excluded <= excluded_n;
      marks    <= marks_n;
      timer    <= timer_n;
    end
  end

`ifdef FALSE_START_PENALTY_EN
  // False-start flags collected while the question is not yet open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fs_flags <= '0;
    else     fs_flags <= fs_flags_n;
  end

  // A buzz in the same cycle as start still counts as a false start
  assign fs_load = fs_flags | buzz;
`endif

  // Next-state and datapath update; new_game overrides every state
  always_comb begin
    state_n    = state;
    answer_n   = answer;
    winner_n   = winner;
    excluded_n = excluded;
    marks_n    = marks;
    timer_n    = timer;
    win_hit    = 1'b0;
`ifdef FALSE_START_PENALTY_EN
    fs_flags_n = fs_flags;
`endif
    if (new_game) begin
      state_n    = IDLE;
      answer_n   = '0;
      winner_n   = '0;
      excluded_n = '0;
      marks_n    = '0;
      timer_n    = '0;
`ifdef FALSE_START_PENALTY_EN
      fs_flags_n = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef FALSE_START_PENALTY_EN
          fs_flags_n = fs_load;
          if (start_e) begin
            fs_flags_n = '0;
            // With everyone flagged there is nobody left to answer
            if (!(&fs_load)) begin
              state_n    = ARMED;
              answer_n   = '0;
              excluded_n = fs_load;
            end
          end
`else
          if (start_e) begin
            state_n    = ARMED;
            answer_n   = '0;
            excluded_n = '0;
          end
`endif
        end
        ARMED: begin
          if (|grant) begin
            answer_n = grant;
            timer_n  = '0;
            state_n  = LOCKED;
          end
        end
        LOCKED: begin
          timer_n = timer + 1'b1;
          if (ok_e && !ng_e) begin
            for (int i = 0; i < PLAYER_N; i++) begin
              if (answer[i]) begin
                marks_n[i] = mark_inc_sat(marks[i], MAX_M);
                if (marks_n[i] == MAX_M) win_hit = 1'b1;
              end
            end
            if (win_hit) begin
              winner_n = answer;
              state_n  = GAME_OVER;
            end else begin
              state_n  = IDLE;
            end
          end else if ((ng_e && !ok_e) || timeout) begin
            // Wrong or silent: lock this player out and reopen to the rest.
            // Once everyone has failed, keep the last answerer on display.
            excluded_n = excluded | answer;
            if (&excluded_n) begin
              state_n = IDLE;
            end else begin
              answer_n = '0;
              state_n  = ARMED;
            end
          end
        end
        GAME_OVER: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign armed      = (state == ARMED);
  assign mark_one   = marks[0];
  assign mark_two   = marks[1];
  assign mark_three = marks[2];
  assign mark_four  = marks[3];

endmodule
